// File: rtl/u_imem_inst_encoder.sv
// RV32I field-level instruction encoder that writes packed words to sequential IMEM addresses.
// Optional `ENC_RANGE_CHECK_EN` rejects immediates that do not fit their format (err_range).
`timescale 1ns/1ps

`ifndef RF_DEPTH_BIT
`define RF_DEPTH_BIT 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module u_imem_inst_encoder #(
  parameter int          IMEM_ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR       = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       req_vld,
  output logic                       req_rdy,
  input  logic [5:0]                 req_op,
  input  logic [`RF_DEPTH_BIT-1:0]   req_rd,
  input  logic [`RF_DEPTH_BIT-1:0]   req_rs1,
  input  logic [`RF_DEPTH_BIT-1:0]   req_rs2,
  input  logic [`DATA_WIDTH-1:0]     req_imm,
  output logic                       imem_wen,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_waddr,
  output logic [`INST_WIDTH-1:0]     imem_wdata,
  output logic                       done,
  output logic                       err_illegal,
  output logic                       err_range
);

  localparam logic [IMEM_ADDR_WIDTH-1:0] BASE = BASE_ADDR[IMEM_ADDR_WIDTH-1:0];
  localparam logic [5:0] OP_WFI = 6'd37;

  typedef enum logic [2:0] {S_OFF, S_IDLE, S_ENC, S_WR, S_DONE} state_e;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS} fmt_e;

  state_e                     state;
  logic [5:0]                 op_q;
  logic [`RF_DEPTH_BIT-1:0]   rd_q;
  logic [`RF_DEPTH_BIT-1:0]   rs1_q;
  logic [`RF_DEPTH_BIT-1:0]   rs2_q;
  logic [`DATA_WIDTH-1:0]     imm_q;

  fmt_e        fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        enc_illegal;
  logic [31:0] enc_word;

  // Op index decode: format class plus the fixed opcode/funct fields.
  always_comb begin
    fmt         = FMT_R;
    opcode      = 7'h33;
    funct3      = 3'd0;
    funct7      = 7'h00;
    enc_illegal = 1'b0;
    case (op_q)
      6'd0:  begin fmt = FMT_U; opcode = 7'h37; end
      6'd1:  begin fmt = FMT_U; opcode = 7'h17; end
      6'd2:  begin fmt = FMT_J; opcode = 7'h6F; end
      6'd3:  begin fmt = FMT_I; opcode = 7'h67; end
      6'd4:  begin fmt = FMT_B; opcode = 7'h63; funct3 = 3'd0; end
      6'd5:  begin fmt = FMT_B; opcode = 7'h63; funct3 = 3'd1; end
      6'd6:  begin fmt = FMT_B; opcode = 7'h63; funct3 = 3'd4; end
      6'd7:  begin fmt = FMT_B; opcode = 7'h63; funct3 = 3'd5; end
      6'd8:  begin fmt = FMT_B; opcode = 7'h63; funct3 = 3'd6; end
      6'd9:  begin fmt = FMT_B; opcode = 7'h63; funct3 = 3'd7; end
      6'd10: begin fmt = FMT_I; opcode = 7'h03; funct3 = 3'd0; end
      6'd11: begin fmt = FMT_I; opcode = 7'h03; funct3 = 3'd1; end
      6'd12: begin fmt = FMT_I; opcode = 7'h03; funct3 = 3'd2; end
      6'd13: begin fmt = FMT_I; opcode = 7'h03; funct3 = 3'd4; end
      6'd14: begin fmt = FMT_I; opcode = 7'h03; funct3 = 3'd5; end
      6'd15: begin fmt = FMT_S; opcode = 7'h23; funct3 = 3'd0; end
      6'd16: begin fmt = FMT_S; opcode = 7'h23; funct3 = 3'd1; end
      6'd17: begin fmt = FMT_S; opcode = 7'h23; funct3 = 3'd2; end
      6'd18: begin fmt = FMT_I; opcode = 7'h13; funct3 = 3'd0; end
      6'd19: begin fmt = FMT_I; opcode = 7'h13; funct3 = 3'd2; end
      6'd20: begin fmt = FMT_I; opcode = 7'h13; funct3 = 3'd3; end
      6'd21: begin fmt = FMT_I; opcode = 7'h13; funct3 = 3'd4; end
      6'd22: begin fmt = FMT_I; opcode = 7'h13; funct3 = 3'd6; end
      6'd23: begin fmt = FMT_I; opcode = 7'h13; funct3 = 3'd7; end
      6'd24: begin fmt = FMT_SH; opcode = 7'h13; funct3 = 3'd1; end
      6'd25: begin fmt = FMT_SH; opcode = 7'h13; funct3 = 3'd5; end
      6'd26: begin fmt = FMT_SH; opcode = 7'h13; funct3 = 3'd5; funct7 = 7'h20; end
      6'd27: begin funct3 = 3'd0; end
      6'd28: begin funct3 = 3'd0; funct7 = 7'h20; end
      6'd29: begin funct3 = 3'd1; end
      6'd30: begin funct3 = 3'd2; end
      6'd31: begin funct3 = 3'd3; end
      6'd32: begin funct3 = 3'd4; end
      6'd33: begin funct3 = 3'd5; end
      6'd34: begin funct3 = 3'd5; funct7 = 7'h20; end
      6'd35: begin funct3 = 3'd6; end
      6'd36: begin funct3 = 3'd7; end
      6'd37: begin fmt = FMT_SYS; opcode = 7'h73; end
      default: enc_illegal = 1'b1;
    endcase
  end

  // Fields a format does not use are left at zero by construction.
  always_comb begin
    enc_word = '0;
    case (fmt)
      FMT_R:   enc_word = {funct7, rs2_q, rs1_q, funct3, rd_q, opcode};
      FMT_I:   enc_word = {imm_q[11:0], rs1_q, funct3, rd_q, opcode};
      FMT_SH:  enc_word = {funct7, imm_q[4:0], rs1_q, funct3, rd_q, opcode};
      FMT_S:   enc_word = {imm_q[11:5], rs2_q, rs1_q, funct3, imm_q[4:0], opcode};
      FMT_B:   enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3,
                           imm_q[4:1], imm_q[11], opcode};
      FMT_U:   enc_word = {imm_q[31:12], rd_q, opcode};
      FMT_J:   enc_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, opcode};
      FMT_SYS: enc_word = 32'h1050_0073;
      default: enc_word = '0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic enc_range_bad;
  logic err_range_q;

  always_comb begin
    enc_range_bad = 1'b0;
    case (fmt)
      FMT_I, FMT_S: enc_range_bad = !((&imm_q[31:11]) || !(|imm_q[31:11]));
      FMT_B:  enc_range_bad = !((&imm_q[31:12]) || !(|imm_q[31:12])) || imm_q[0];
      FMT_J:  enc_range_bad = !((&imm_q[31:20]) || !(|imm_q[31:20])) || imm_q[0];
      FMT_U:  enc_range_bad = |imm_q[11:0];
      FMT_SH: enc_range_bad = |imm_q[31:5];
      default: enc_range_bad = 1'b0;
    endcase
  end

  assign err_range = err_range_q;
`else
  assign err_range = 1'b0;
`endif

  // Accept -> encode -> write; start aborts from any state and beats a same-cycle request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_OFF;
      req_rdy     <= 1'b0;
      imem_wen    <= 1'b0;
      imem_waddr  <= BASE;
      imem_wdata  <= '0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
`ifdef ENC_RANGE_CHECK_EN
      err_range_q <= 1'b0;
`endif
    end else if (start) begin
      state       <= S_IDLE;
      req_rdy     <= 1'b1;
      imem_wen    <= 1'b0;
      imem_waddr  <= BASE;
      done        <= 1'b0;
      err_illegal <= 1'b0;
`ifdef ENC_RANGE_CHECK_EN
      err_range_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_vld) begin
            op_q    <= req_op;
            rd_q    <= req_rd;
            rs1_q   <= req_rs1;
            rs2_q   <= req_rs2;
            imm_q   <= req_imm;
            req_rdy <= 1'b0;
            state   <= S_ENC;
          end
        end
        S_ENC: begin
          if (enc_illegal) begin
            err_illegal <= 1'b1;
            req_rdy     <= 1'b1;
            state       <= S_IDLE;
`ifdef ENC_RANGE_CHECK_EN
          end else if (enc_range_bad) begin
            err_range_q <= 1'b1;
            req_rdy     <= 1'b1;
            state       <= S_IDLE;
`endif
          end else begin
            imem_wdata <= enc_word;
            imem_wen   <= 1'b1;
            state      <= S_WR;
          end
        end
        S_WR: begin
          imem_wen <= 1'b0;
          if (imem_waddr != '1) begin
            imem_waddr <= imem_waddr + 1'b1;
          end
          if (op_q == OP_WFI || imem_waddr == '1) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            req_rdy <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_u_imem_inst_encoder.sv
// Directed-vector bench for u_imem_inst_encoder: hand-computed RV32I words, latency,
// WFI/full termination, illegal ops, start priority and async reset during a write.
`timescale 1ns/1ps

module tb_u_imem_inst_encoder;

  localparam int AW   = 4;
  localparam int BASE = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          req_vld;
  logic          req_rdy;
  logic [5:0]    req_op;
  logic [4:0]    req_rd;
  logic [4:0]    req_rs1;
  logic [4:0]    req_rs2;
  logic [31:0]   req_imm;
  logic          imem_wen;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          done;
  logic          err_illegal;
  logic          err_range;

  int vectorCount     = 0;
  int miscompareCount = 0;

  always #5 clk = ~clk;

  u_imem_inst_encoder #(.IMEM_ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .imem_wen(imem_wen), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .done(done), .err_illegal(err_illegal), .err_range(err_range)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic pulseStart;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One request; the write must show up exactly two cycles after acceptance.
  task automatic applyStimulus(input string tag, input logic [5:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm, input bit expWrite,
                               input logic [31:0] expData, input logic [AW-1:0] expAddr);
    int waitCycles = 0;
    while (req_rdy !== 1'b1 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput({tag, " rdy"}, {31'd0, req_rdy}, 32'd1);
    req_op  = op;
    req_rd  = rd;
    req_rs1 = rs1;
    req_rs2 = rs2;
    req_imm = imm;
    req_vld = 1'b1;
    @(negedge clk);
    req_vld = 1'b0;
    req_op  = 6'($urandom);
    req_rd  = 5'($urandom);
    req_rs1 = 5'($urandom);
    req_rs2 = 5'($urandom);
    req_imm = $urandom;
    checkOutput({tag, " wen early"}, {31'd0, imem_wen}, 32'd0);
    @(negedge clk);
    checkOutput({tag, " wen"}, {31'd0, imem_wen}, {31'd0, expWrite});
    if (expWrite) begin
      checkOutput({tag, " addr"}, {28'd0, imem_waddr}, {28'd0, expAddr});
      checkOutput({tag, " data"}, imem_wdata, expData);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; req_vld = 1'b0;
    req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst rdy",   {31'd0, req_rdy},     32'd0);
    checkOutput("rst wen",   {31'd0, imem_wen},    32'd0);
    checkOutput("rst addr",  {28'd0, imem_waddr},  BASE);
    checkOutput("rst data",  imem_wdata,           32'd0);
    checkOutput("rst done",  {31'd0, done},        32'd0);
    checkOutput("rst ill",   {31'd0, err_illegal}, 32'd0);
    checkOutput("rst range", {31'd0, err_range},   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("off rdy", {31'd0, req_rdy}, 32'd0);

    pulseStart;
    checkOutput("start rdy", {31'd0, req_rdy}, 32'd1);

    applyStimulus("addi", 6'd18, 5'd1, 5'd0, 5'd0, 32'd5,          1, 32'h0050_0093, 4'd2);
    applyStimulus("lui",  6'd0,  5'd2, 5'd0, 5'd0, 32'h1234_5000,  1, 32'h1234_5137, 4'd3);
    applyStimulus("sub",  6'd28, 5'd3, 5'd1, 5'd2, 32'd0,          1, 32'h4020_81B3, 4'd4);
    applyStimulus("beq",  6'd4,  5'd0, 5'd1, 5'd2, -32'sd8,        1, 32'hFE20_8CE3, 4'd5);
    applyStimulus("sw",   6'd17, 5'd0, 5'd1, 5'd2, 32'd4,          1, 32'h0020_A223, 4'd6);
    applyStimulus("jal",  6'd2,  5'd1, 5'd0, 5'd0, 32'h800,        1, 32'h0010_00EF, 4'd7);
    applyStimulus("srai", 6'd26, 5'd5, 5'd6, 5'd0, 32'd3,          1, 32'h4033_5293, 4'd8);
    applyStimulus("lw",   6'd12, 5'd7, 5'd2, 5'd0, -32'sd4,        1, 32'hFFC1_2383, 4'd9);
    applyStimulus("wfi",  6'd37, 5'd0, 5'd0, 5'd0, 32'd0,          1, 32'h1050_0073, 4'd10);
    @(negedge clk);
    checkOutput("wfi done", {31'd0, done},    32'd1);
    checkOutput("wfi rdy",  {31'd0, req_rdy}, 32'd0);
    req_vld = 1'b1;
    req_op  = 6'd18;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("done nowrite", {31'd0, imem_wen}, 32'd0);
    end
    req_vld = 1'b0;

    pulseStart;
    checkOutput("restart addr", {28'd0, imem_waddr}, BASE);
    checkOutput("restart done", {31'd0, done},       32'd0);
    checkOutput("restart rdy",  {31'd0, req_rdy},    32'd1);

    applyStimulus("illegal", 6'd45, 5'd1, 5'd1, 5'd1, 32'd1, 0, 32'd0, 4'd0);
    checkOutput("illegal flag", {31'd0, err_illegal}, 32'd1);
    applyStimulus("addi after ill", 6'd18, 5'd1, 5'd0, 5'd0, 32'd5, 1, 32'h0050_0093, 4'd2);
`ifdef ENC_RANGE_CHECK_EN
    applyStimulus("addi 2048", 6'd18, 5'd0, 5'd0, 5'd0, 32'd2048, 0, 32'd0, 4'd0);
    checkOutput("range flag", {31'd0, err_range}, 32'd1);
`else
    applyStimulus("addi 2048", 6'd18, 5'd0, 5'd0, 5'd0, 32'd2048, 1, 32'h8000_0013, 4'd3);
    checkOutput("range tied", {31'd0, err_range}, 32'd0);
`endif

    // start and req_vld together: the request must be dropped
    @(negedge clk);
    start   = 1'b1;
    req_vld = 1'b1;
    req_op  = 6'd18;
    @(negedge clk);
    start   = 1'b0;
    req_vld = 1'b0;
    checkOutput("race rdy",   {31'd0, req_rdy},     32'd1);
    checkOutput("race ill",   {31'd0, err_illegal}, 32'd0);
    checkOutput("race addr",  {28'd0, imem_waddr},  BASE);
    @(negedge clk);
    checkOutput("race nowen", {31'd0, imem_wen},    32'd0);
    checkOutput("race rdy2",  {31'd0, req_rdy},     32'd1);

    for (int a = BASE; a < 16; a++) begin
      applyStimulus($sformatf("fill%0d", a), 6'd18, 5'd1, 5'd0, 5'd0, 32'(a), 1,
                    (32'(a) << 20) | 32'h93, AW'(a));
    end
    @(negedge clk);
    checkOutput("full done", {31'd0, done},       32'd1);
    checkOutput("full addr", {28'd0, imem_waddr}, 32'd15);
    checkOutput("full rdy",  {31'd0, req_rdy},    32'd0);

    pulseStart;
    req_op = 6'd18; req_rd = 5'd1; req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 32'd5;
    req_vld = 1'b1;
    @(negedge clk);
    req_vld = 1'b0;
    @(negedge clk);
    checkOutput("midwr wen", {31'd0, imem_wen}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async wen",  {31'd0, imem_wen},   32'd0);
    checkOutput("async addr", {28'd0, imem_waddr}, BASE);
    checkOutput("async rdy",  {31'd0, req_rdy},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
